// File: rtl/id_stage_pipe.sv
// MIPS decode stage for logic/shift/lui instructions with EX/MEM forwarding,
// load-use interlock and a valid/ready ID/EX pipeline register with flush.
module id_stage_pipe #(
   parameter bit FWD_EN        = 1'b1,
   parameter bit STRICT_DECODE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   output logic        reg1_read_o,
   output logic [4:0]  reg1_addr_o,
   output logic        reg2_read_o,
   output logic [4:0]  reg2_addr_o,
   input  logic [31:0] reg1_data_i,
   input  logic [31:0] reg2_data_i,
   input  logic        ex_wreg_i,
   input  logic [4:0]  ex_wd_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        ex_is_load_i,
   input  logic        mem_wreg_i,
   input  logic [4:0]  mem_wd_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        flush_i,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] pc_o,
   output logic [7:0]  aluop_o,
   output logic [2:0]  alusel_o,
   output logic [31:0] reg1_o,
   output logic [31:0] reg2_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic        instvalid_o
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] F_SLL      = 6'h00;
   localparam logic [5:0] F_SRL      = 6'h02;
   localparam logic [5:0] F_SRA      = 6'h03;
   localparam logic [5:0] F_AND      = 6'h24;
   localparam logic [5:0] F_OR       = 6'h25;
   localparam logic [5:0] F_XOR      = 6'h26;
   localparam logic [5:0] F_NOR      = 6'h27;
   localparam logic [7:0] ALU_OR     = 8'h25;
   localparam logic [7:0] ALU_AND    = 8'h24;
   localparam logic [7:0] ALU_XOR    = 8'h26;
   localparam logic [7:0] ALU_NOR    = 8'h27;
   localparam logic [7:0] ALU_SLL    = 8'h7C;
   localparam logic [7:0] ALU_SRL    = 8'h02;
   localparam logic [7:0] ALU_SRA    = 8'h03;
   localparam logic [2:0] SEL_LOGIC  = 3'b001;
   localparam logic [2:0] SEL_SHIFT  = 3'b010;

   logic [5:0]  op_s, func_s;
   logic [4:0]  rs_s, rt_s, rd_s, sa_s;
   logic [15:0] imm_s;
   logic [7:0]  dec_aluop_s;
   logic [2:0]  dec_alusel_s;
   logic [4:0]  dec_wd_s;
   logic        dec_wreg_s, dec_valid_s, dec_rd1_s, dec_rd2_s;
   logic [31:0] dec_imm1_s, dec_imm2_s;
   logic [31:0] op1_s, op2_s;
   logic        hazard_s, adv_s;

   logic        out_valid_r, wreg_r, instvalid_r;
   logic [31:0] pc_r, reg1_r, reg2_r;
   logic [7:0]  aluop_r;
   logic [2:0]  alusel_r;
   logic [4:0]  wd_r;

   assign op_s   = inst_i[31:26];
   assign rs_s   = inst_i[25:21];
   assign rt_s   = inst_i[20:16];
   assign rd_s   = inst_i[15:11];
   assign sa_s   = inst_i[10:6];
   assign func_s = inst_i[5:0];
   assign imm_s  = inst_i[15:0];

   // EX result wins over MEM; register 0 always reads as zero.
   function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] rf,
                                           input logic ex_w, input logic [4:0] ex_a,
                                           input logic [31:0] ex_d, input logic mem_w,
                                           input logic [4:0] mem_a, input logic [31:0] mem_d);
      logic [31:0] v;
      if (addr == 5'd0) begin
         v = 32'h0000_0000;
      end else if (FWD_EN && ex_w && (ex_a == addr)) begin
         v = ex_d;
      end else if (FWD_EN && mem_w && (mem_a == addr)) begin
         v = mem_d;
      end else begin
         v = rf;
      end
      return v;
   endfunction

   function automatic logic port_hazard(input logic en, input logic [4:0] addr,
                                        input logic ex_w, input logic [4:0] ex_a,
                                        input logic ex_ld, input logic mem_w,
                                        input logic [4:0] mem_a);
      logic ex_hit, mem_hit, h;
      ex_hit  = ex_w && (ex_a == addr);
      mem_hit = mem_w && (mem_a == addr);
      if (!en || (addr == 5'd0)) begin
         h = 1'b0;
      end else if (FWD_EN) begin
         h = ex_hit && ex_ld;
      end else begin
         h = ex_hit || mem_hit;
      end
      return h;
   endfunction

   // Instruction decode: ALU op/class, destination and which source fields are used.
   always_comb begin
      dec_aluop_s  = 8'h00;
      dec_alusel_s = 3'b000;
      dec_wd_s     = 5'd0;
      dec_wreg_s   = 1'b0;
      dec_valid_s  = 1'b0;
      dec_rd1_s    = 1'b0;
      dec_rd2_s    = 1'b0;
      dec_imm1_s   = 32'h0000_0000;
      dec_imm2_s   = 32'h0000_0000;
      case (op_s)
         OP_SPECIAL: begin
            case (func_s)
               F_AND, F_OR, F_XOR, F_NOR: begin
                  if (!STRICT_DECODE || (sa_s == 5'd0)) begin
                     dec_valid_s  = 1'b1;
                     dec_wreg_s   = 1'b1;
                     dec_wd_s     = rd_s;
                     dec_rd1_s    = 1'b1;
                     dec_rd2_s    = 1'b1;
                     dec_alusel_s = SEL_LOGIC;
                     case (func_s)
                        F_AND:   dec_aluop_s = ALU_AND;
                        F_OR:    dec_aluop_s = ALU_OR;
                        F_XOR:   dec_aluop_s = ALU_XOR;
                        default: dec_aluop_s = ALU_NOR;
                     endcase
                  end else begin
                     dec_valid_s = 1'b0;
                  end
               end
               F_SLL, F_SRL, F_SRA: begin
                  if (!STRICT_DECODE || (rs_s == 5'd0)) begin
                     dec_valid_s  = 1'b1;
                     dec_wreg_s   = 1'b1;
                     dec_wd_s     = rd_s;
                     dec_rd2_s    = 1'b1;
                     dec_imm1_s   = {27'd0, sa_s};
                     dec_alusel_s = SEL_SHIFT;
                     case (func_s)
                        F_SLL:   dec_aluop_s = ALU_SLL;
                        F_SRL:   dec_aluop_s = ALU_SRL;
                        default: dec_aluop_s = ALU_SRA;
                     endcase
                  end else begin
                     dec_valid_s = 1'b0;
                  end
               end
               default: dec_valid_s = 1'b0;
            endcase
         end
         OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
            dec_valid_s  = 1'b1;
            dec_wreg_s   = 1'b1;
            dec_wd_s     = rt_s;
            dec_rd1_s    = 1'b1;
            dec_alusel_s = SEL_LOGIC;
            dec_imm2_s   = {16'h0000, imm_s};
            case (op_s)
               OP_ANDI: dec_aluop_s = ALU_AND;
               OP_XORI: dec_aluop_s = ALU_XOR;
               OP_LUI: begin
                  dec_aluop_s = ALU_OR;
                  dec_imm2_s  = {imm_s, 16'h0000};
               end
               default: dec_aluop_s = ALU_OR;
            endcase
         end
         default: dec_valid_s = 1'b0;
      endcase
   end

   assign reg1_read_o = rst & in_valid & dec_rd1_s;
   assign reg2_read_o = rst & in_valid & dec_rd2_s;
   assign reg1_addr_o = rst ? rs_s : 5'd0;
   assign reg2_addr_o = rst ? rt_s : 5'd0;

   // Operand selection: forwarded/regfile value for used ports, immediates otherwise.
   always_comb begin
      op1_s = dec_imm1_s;
      op2_s = dec_imm2_s;
      if (dec_rd1_s) begin
         op1_s = fwd_sel(rs_s, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                         mem_wreg_i, mem_wd_i, mem_wdata_i);
      end else begin
         op1_s = dec_imm1_s;
      end
      if (dec_rd2_s) begin
         op2_s = fwd_sel(rt_s, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                         mem_wreg_i, mem_wd_i, mem_wdata_i);
      end else begin
         op2_s = dec_imm2_s;
      end
   end

   assign hazard_s = rst & in_valid &
                     (port_hazard(dec_rd1_s, rs_s, ex_wreg_i, ex_wd_i, ex_is_load_i,
                                  mem_wreg_i, mem_wd_i) |
                      port_hazard(dec_rd2_s, rt_s, ex_wreg_i, ex_wd_i, ex_is_load_i,
                                  mem_wreg_i, mem_wd_i));
   assign adv_s    = out_ready | ~out_valid_r;
   assign in_ready = rst & ((adv_s & ~hazard_s) | flush_i);

   // ID/EX register: flush beats bubble beats load; payload kept when only valid drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         pc_r        <= 32'h0000_0000;
         aluop_r     <= 8'h00;
         alusel_r    <= 3'b000;
         reg1_r      <= 32'h0000_0000;
         reg2_r      <= 32'h0000_0000;
         wd_r        <= 5'd0;
         wreg_r      <= 1'b0;
         instvalid_r <= 1'b0;
      end else if (flush_i) begin
         out_valid_r <= 1'b0;
      end else if (adv_s && hazard_s) begin
         out_valid_r <= 1'b0;
      end else if (adv_s) begin
         out_valid_r <= in_valid;
         pc_r        <= pc_i;
         aluop_r     <= dec_aluop_s;
         alusel_r    <= dec_alusel_s;
         reg1_r      <= op1_s;
         reg2_r      <= op2_s;
         wd_r        <= dec_wd_s;
         wreg_r      <= dec_wreg_s;
         instvalid_r <= dec_valid_s;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid   = out_valid_r;
   assign pc_o        = pc_r;
   assign aluop_o     = aluop_r;
   assign alusel_o    = alusel_r;
   assign reg1_o      = reg1_r;
   assign reg2_o      = reg2_r;
   assign wd_o        = wd_r;
   assign wreg_o      = wreg_r;
   assign instvalid_o = instvalid_r;

endmodule
